inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Read-only, direct-mapped instruction cache that responds to the fetch stage's PC-addressed instruction requests.
- Hits return the instruction word in the request cycle.
- Misses fetch a full 256-bit line from physical memory through the cacheline adapter, install it, then return the word.
- Sits between the IF stage (initiator) and the instruction-side pmem port.

Parameters:
- S_INDEX, 3, log2 of number of sets (8 sets).
- S_OFFSET, 5, log2 of line size in bytes (32 B = 256 bits); fixed by the pmem interface.
- S_TAG, 32-S_INDEX-S_OFFSET, tag width (24 at defaults); derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low. The name follows the codebase; asserted when 0.
- inst_read  input  1  fetch request valid.
- inst_addr  input  32  fetch PC; bits [1:0] ignored.
- inst_rdata  output  32  instruction word; valid when inst_resp=1.
- inst_resp  output  1  request complete this cycle.
- pmem_read  output  1  line fill request to the cacheline adapter.
- pmem_address  output  32  line-aligned fill address; bits [4:0]=0.
- pmem_rdata  input  256  returned line; word k at bits [32k+31:32k].
- pmem_resp  input  1  fill data valid, single-cycle pulse.

Behaviour:
- Address split:
  - tag = inst_addr[31:8]
  - index = inst_addr[7:5]
  - word = inst_addr[4:2]
- Storage: per set one valid bit, an S_TAG tag and a 256-bit line, all flops.
- Reset (rst=0, asynchronous):
  - all valid bits cleared; state=IDLE.
  - inst_resp=0, pmem_read=0, pmem_address=0, inst_rdata=0.
  - Tag and data contents are don't-care.
- FSM states: IDLE, FILL.
- IDLE:
  - hit = inst_read & valid[index] & (tag_array[index]==tag).
  - On hit: inst_resp=1 and inst_rdata=line[index][word] combinationally in the same cycle (0-cycle hit latency).
  - On inst_read & !hit: inst_resp=0; latch {tag,index}; next state FILL.
  - When inst_read=0, inst_resp=0.
- FILL:
  - pmem_read=1 and pmem_address={latched tag, latched index, 5'b0}, held stable until pmem_resp.
  - On pmem_resp: write pmem_rdata into line[index], write tag, set valid; next state IDLE.
  - inst_resp=0 throughout FILL.
- Miss latency: the IDLE cycle after the fill returns is a hit, so inst_resp rises one cycle after pmem_resp. Total = 1 + pmem latency + 1 cycles from request.
- Requester rule: hold inst_read and inst_addr stable until inst_resp.
- If inst_read drops, or inst_addr changes, during FILL:
  - the fill still completes and installs the latched line (no abort).
  - the new request is evaluated in IDLE afterwards.
- Conflict: a miss to an occupied set overwrites the old line. No write-back is needed because the cache is read-only.
- Reset during FILL: pmem_read drops immediately. The line is not installed, and a pmem_resp arriving under or after reset is ignored.
- inst_rdata when inst_resp=0: drive the indexed word, or 0. The bench must not check it.
- No writes and no flush; self-modifying code is unsupported.

Decomposition:
- Shared package icache_types:
  - S_OFFSET/S_INDEX/S_TAG constants.
  - icache_state_t enum {IDLE, FILL}.
  - Typedefs tag_t and line_t (256 bits).
- Sub-module icache_array holds valid/tag/data:
  - one write port (index, tag, line, we).
  - asynchronous read by index.
  - valid cleared by rst.
- FSM and hit logic live in inst_cache.

Test Plan:
- Cold miss: reset, inst_read=1, inst_addr=0x00000060.
  - pmem_read=1 with pmem_address=0x00000060 from the next cycle.
  - pmem_resp with pmem_rdata word3=0x00A00093.
  - One cycle later inst_resp=1, inst_rdata=0x00A00093.
- Same-line hits: after that fill, addr 0x00000064 then 0x00000070.
  - inst_resp=1 in the request cycle each time.
  - Data matches words 1 and 4 of the line.
  - pmem_read stays 0.
- Conflict eviction: fill 0x00000060, then request 0x00000160 (same index 3).
  - Miss with pmem_address=0x00000160.
  - Re-request 0x00000060 misses again.
- Request dropped mid-fill: miss on 0x00000080, deassert inst_read while in FILL.
  - Fill completes on pmem_resp.
  - A later request to 0x00000080 hits with no pmem_read.
- Reset mid-fill: miss on 0x00000020, pull rst=0 two cycles into FILL, then pulse pmem_resp.
  - pmem_read=0 immediately.
  - After release, 0x00000020 misses (line not installed).
- Low-bit ignore: request 0x00000063 after filling 0x00000060.
  - Hit; returns word 0 of the line, same as 0x00000060.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared geometry constants, FSM state encoding and storage types for the
// direct-mapped instruction cache.
package icache_types;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
  localparam int S_LINE   = 8 * (1 << S_OFFSET);
  localparam int N_SETS   = 1 << S_INDEX;

  typedef enum logic {
    IDLE,
    FILL
  } icache_state_t;

  typedef logic [S_TAG-1:0]   tag_t;
  typedef logic [S_INDEX-1:0] index_t;
  typedef logic [S_LINE-1:0]  line_t;

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the instruction cache: one write port and an
// asynchronous read port, both addressed by set index.
module icache_array
  import icache_types::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   we,
  input  index_t w_index,
  input  tag_t   w_tag,
  input  line_t  w_line,
  input  index_t r_index,
  output logic   r_valid,
  output tag_t   r_tag,
  output line_t  r_line
);

  logic [N_SETS-1:0] valid;
  tag_t              tags  [N_SETS];
  line_t             lines [N_SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (we) begin
      valid[w_index] <= 1'b1;
    end
  end

  // Tag and data carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[w_index]  <= w_tag;
      lines[w_index] <= w_line;
    end
  end

  assign r_valid = valid[r_index];
  assign r_tag   = tags[r_index];
  assign r_line  = lines[r_index];

endmodule

// File: rtl/inst_cache.sv
// Read-only direct-mapped instruction cache: zero-latency hits, line fill
// from the instruction-side pmem port on a miss.
module inst_cache
  import icache_types::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_read,
  input  logic [31:0]   inst_addr,
  output logic [31:0]   inst_rdata,
  output logic          inst_resp,
  output logic          pmem_read,
  output logic [31:0]   pmem_address,
  input  logic [255:0]  pmem_rdata,
  input  logic          pmem_resp
);

  icache_state_t state, state_d;

  tag_t        req_tag;
  index_t      req_index;
  logic [2:0]  req_word;
  logic        unused_addr_bits;

  tag_t        fill_tag;
  index_t      fill_index;

  logic        arr_we;
  logic        arr_valid;
  tag_t        arr_tag;
  line_t       arr_line;
  logic        hit;

  assign req_tag          = inst_addr[31 -: S_TAG];
  assign req_index        = inst_addr[S_OFFSET +: S_INDEX];
  assign req_word         = inst_addr[S_OFFSET-1:2];
  assign unused_addr_bits = ^inst_addr[1:0];

  icache_array u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (arr_we),
    .w_index (fill_index),
    .w_tag   (fill_tag),
    .w_line  (pmem_rdata),
    .r_index (req_index),
    .r_valid (arr_valid),
    .r_tag   (arr_tag),
    .r_line  (arr_line)
  );

  assign hit = inst_read & arr_valid & (arr_tag == req_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Miss address is captured once so the fill stays stable even if the
  // requester misbehaves while the line is in flight.
  always_ff @(posedge clk) begin
    if (state == IDLE && inst_read && !hit) begin
      fill_tag   <= req_tag;
      fill_index <= req_index;
    end
  end

  always_comb begin
    state_d      = state;
    inst_resp    = 1'b0;
    inst_rdata   = '0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    arr_we       = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          inst_resp  = 1'b1;
          inst_rdata = arr_line[{req_word, 5'b0} +: 32];
        end else if (inst_read) begin
          state_d = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {fill_tag, fill_index, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          arr_we  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: stimulus queues expected responses and fill
// addresses; a negedge monitor pops and compares them as the DUT presents them.
module tb_inst_cache;

  logic         clk;
  logic         rst;
  logic         inst_read;
  logic [31:0]  inst_addr;
  logic [31:0]  inst_rdata;
  logic         inst_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_resp[$];
  logic [31:0] exp_fill[$];
  logic        pr_d = 1'b0;
  logic [31:0] cur_fill = '0;

  logic [255:0] line_a, line_b, line_c, line_d_junk, line_d;

  inst_cache dut (
    .clk          (clk),
    .rst          (rst),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_resp    (inst_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mkline(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + k;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response and every new fill request must have been queued.
  always @(negedge clk) begin
    if (inst_resp) begin
      if (exp_resp.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        chk("resp_data", inst_rdata, exp_resp.pop_front());
      end
    end
    if (pmem_read) begin
      if (!pr_d) begin
        if (exp_fill.size() == 0) begin
          chk("fill_unexpected", pmem_address, 32'hFFFF_FFFF);
        end else begin
          cur_fill = exp_fill.pop_front();
          chk("fill_addr", pmem_address, cur_fill);
        end
      end else begin
        chk("fill_hold", pmem_address, cur_fill);
      end
    end
    pr_d = pmem_read;
  end

  task automatic do_miss(input logic [31:0] addr, input logic [255:0] line,
                         input int lat, input logic [31:0] exp_word);
    inst_read = 1'b1;
    inst_addr = addr;
    exp_fill.push_back({addr[31:5], 5'b0});
    exp_resp.push_back(exp_word);
    @(negedge clk);
    chk("miss_no_resp", {31'd0, inst_resp}, 32'd0);
    tick();
    chk("fill_req", {31'd0, pmem_read}, 32'd1);
    repeat (lat) tick();
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    @(negedge clk);
    chk("miss_resp_lat", {31'd0, inst_resp}, 32'd1);
    tick();
    inst_read = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp_word);
    inst_read = 1'b1;
    inst_addr = addr;
    exp_resp.push_back(exp_word);
    @(negedge clk);
    chk("hit_resp", {31'd0, inst_resp}, 32'd1);
    chk("hit_no_fill", {31'd0, pmem_read}, 32'd0);
    tick();
    inst_read = 1'b0;
  endtask

  initial begin
    line_a = {32'h0063A313, 32'h00528293, 32'h0041A213, 32'h00318193,
              32'h00A00093, 32'h00210113, 32'h00108093, 32'h00A00093};
    line_b      = mkline(32'hB000_0000);
    line_c      = mkline(32'hC000_0000);
    line_d_junk = mkline(32'hDEAD_0000);
    line_d      = mkline(32'hD200_0000);

    rst        = 1'b0;
    inst_read  = 1'b1;
    inst_addr  = 32'h0000_0060;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    #2;
    chk("rst_resp",  {31'd0, inst_resp}, 32'd0);
    chk("rst_pread", {31'd0, pmem_read}, 32'd0);
    chk("rst_paddr", pmem_address, 32'd0);
    chk("rst_rdata", inst_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b1;
    inst_read = 1'b0;
    tick();

    // Cold miss, then same-line hits and low-bit ignore
    do_miss(32'h0000_0060, line_a, 2, 32'h00A00093);
    do_hit(32'h0000_0064, 32'h00108093);
    do_hit(32'h0000_0070, 32'h00318193);
    do_hit(32'h0000_0063, 32'h00A00093);

    // Conflict on index 3
    do_miss(32'h0000_0160, line_b, 1, 32'hB000_0000);
    do_hit(32'h0000_017C, 32'hB000_0007);
    do_miss(32'h0000_0060, line_a, 0, 32'h00A00093);

    // Request dropped and address changed during FILL
    inst_read = 1'b1;
    inst_addr = 32'h0000_0080;
    exp_fill.push_back(32'h0000_0080);
    tick();
    inst_read = 1'b0;
    inst_addr = 32'h0000_01E0;
    tick();
    pmem_rdata = line_c;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    @(negedge clk);
    chk("drop_no_resp", {31'd0, inst_resp}, 32'd0);
    chk("drop_fill_done", {31'd0, pmem_read}, 32'd0);
    tick();
    do_hit(32'h0000_0080, 32'hC000_0000);
    do_hit(32'h0000_0088, 32'hC000_0002);

    // Reset two cycles into a fill
    inst_read = 1'b1;
    inst_addr = 32'h0000_0020;
    exp_fill.push_back(32'h0000_0020);
    tick();
    tick();
    chk("fill_before_rst", {31'd0, pmem_read}, 32'd1);
    rst       = 1'b0;
    inst_read = 1'b0;
    #1;
    chk("rst_drops_pread", {31'd0, pmem_read}, 32'd0);
    chk("rst_clears_paddr", pmem_address, 32'd0);
    pmem_rdata = line_d_junk;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    @(negedge clk);
    chk("stray_resp_ignored", {31'd0, pmem_read}, 32'd0);
    tick();
    do_miss(32'h0000_0020, line_d, 1, 32'hD200_0000);

    // Earlier lines were wiped by reset
    do_miss(32'h0000_0064, line_a, 0, 32'h00108093);

    repeat (3) tick();
    chk("resp_queue_empty", exp_resp.size(), 32'd0);
    chk("fill_queue_empty", exp_fill.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
